stark_decode_sched: RTL
=======================

Name: stark_decode_sched

Overview:
- Micro-op queue and group scheduler that sits between instruction extraction and the four Stark decoders.
- Accepts up to four micro-ops per cycle, compacts them in program order, and buffers them in a circular queue.
- Presents a registered group of up to four micro-ops to the decoders, under a stall handshake from rename.
- Nullifies queued entries that a cache-line constant report identifies as constant words, so constants never reach decode as instructions.

Parameters:
- QDEPTH, 16: queue entries; power of two, at least 8.
- LTAG_W, 4: cache-line tag width used to match constant reports.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; discards all buffered micro-ops.
- in_valid  in  1  input group valid.
- in_ready  out  1  queue can accept a full group of 4.
- in_slot_v  in  4  per-slot valid within the input group.
- in_uop  in  4 x $bits(micro_op_t)  input micro-ops.
- in_pos  in  4 x 4  word position of each slot within its 512-bit cache line.
- in_line  in  LTAG_W  cache-line tag of the input group.
- ck_valid  in  1  constant-kill report valid.
- ck_line  in  LTAG_W  line tag for the report.
- ck_mask  in  16  word positions in that line that hold constants.
- out_ready  in  1  decoders can accept a group (inverse of rename stall).
- out_v  out  4  per-slot valid of the presented group.
- out_nop  out  4  slot was killed; decoder treats it as invalid (instr.v=0).
- out_uop  out  4 x $bits(micro_op_t)  presented micro-ops.
- q_count  out  $clog2(QDEPTH)+1  occupancy, for performance monitoring.

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail and count are 0.
  - out_v=0, out_nop=0, out_uop=0.
  - in_ready=1 and q_count=0.
- Storage:
  - Each entry holds {uop, pos, line, kill}.
  - head and tail are $clog2(QDEPTH)+1 bits wide; the extra bit is the wrap bit, so full and empty are distinguished; indices wrap modulo QDEPTH.
- Enqueue:
  - An input fire is in_valid & in_ready.
  - Slots whose in_slot_v bit is set are compacted in ascending slot order and written at tail, tail+1, and so on.
  - tail advances by popcount(in_slot_v); a fire with in_slot_v=0 is a no-op.
- in_ready:
  - Registered.
  - Asserted next cycle iff QDEPTH - count_next >= 4.
- Output stage:
  - A load occurs when out_ready=1 or out_v==0.
  - On a load with n = min(count, 4): out_uop[i] and out_nop[i] take entry head+i for i<n; out_v = (1<<n)-1; head += n.
  - Slots i>=n are driven with out_v[i]=0 and out_uop[i]=0.
  - With no load, all outputs hold.
  - Latency: an entry written in cycle t can appear on the outputs at the load of cycle t+1 at the earliest. There is no same-cycle bypass.
- Count:
  - count_next = count + enq_n - deq_n.
  - Simultaneous enqueue and dequeue are legal, including while full minus 4.
- Constant kill:
  - When ck_valid=1, every stored entry with line==ck_line and ck_mask[pos]=1 gets kill=1.
  - Input slots enqueued in the same cycle are checked against the same report.
  - The already-presented output group is NOT modified; the decoder's mark_nops handles that group.
  - A killed entry still occupies a slot and is delivered with out_nop=1, which preserves slot alignment with consts_pos.
- Flush:
  - Flush has the highest priority over everything.
  - Next cycle: head=tail=0, count=0, out_v=0, in_ready=1.
  - An enqueue, kill or load in the flush cycle is discarded.
- Boundaries:
  - Overflow is prevented by in_ready; an enqueue while in_ready=0 is ignored and is an assertion error.
  - When empty with out_ready=1, out_v becomes 0.
  - Wrap-around of head and tail across index QDEPTH-1 to 0 is seamless within a single group.
  - Reset during operation behaves as reset, asynchronously, regardless of handshake state.

Decomposition:
- Stark_pkg:
  - DEC_WIDTH=4 constant.
  - dsq_entry_t struct {micro_op_t uop; logic [3:0] pos; logic [LTAG_W-1:0] line; logic kill}.
- One natural sub-module, stark_dsq_compact: purely combinational 4-slot in-order compaction. It produces the write offsets and the enqueue count.
- Popcount and the n=min(count,4) logic stay inline.

Test Plan:
- Reset, then enqueue in_slot_v=4'b1011 (uops A,B,D), out_ready=1 → the next load presents out_v=4'b0111 with A,B,D in slots 0-2; q_count returns to 0.
- Hold out_ready=0 while enqueuing full groups → in_ready drops once count reaches 13 (QDEPTH=16) and no enqueue occurs while in_ready=0. The presented group stays stable while out_ready=0, and every uop emerges in order once out_ready=1.
- Enqueue line 3 with positions 4,5,6,7; then ck_valid with ck_line=3, ck_mask=16'h0060 → positions 5,6 are delivered with out_nop=4'b0110 and positions 4,7 with out_nop=0. A report with ck_line=2 leaves all entries unkilled.
- Steady enqueue and dequeue of 4 per cycle for 40 cycles → head and tail wrap at least twice, ordering is preserved, and q_count stays constant.
- Assert flush with 10 entries queued and a simultaneous in_valid → the next cycle has q_count=0, out_v=0, in_ready=1, and no flushed uop ever appears.
- Drive rst low asynchronously mid-transfer → all outputs reach their reset values before the next clk edge.

Source files
------------

// File: rtl/stark_pkg.sv
// Shared types and constants for the Stark decode-side micro-op scheduler.
package stark_pkg;

    // Number of decoder slots fed per cycle
    localparam int unsigned DEC_WIDTH = 4;
    // Default cache-line tag width used by constant-kill matching
    localparam int unsigned LTAG_W    = 4;

    // Micro-op as produced by instruction extraction
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
    } micro_op_t;

    // One queue entry: the micro-op plus what is needed to match constant reports
    typedef struct packed {
        micro_op_t         uop;
        logic [3:0]        pos;
        logic [LTAG_W-1:0] line;
        logic              kill;
    } dsq_entry_t;

endpackage

// File: rtl/stark_dsq_compact.sv
// In-order compaction of a 4-slot input group: per-slot write offset and total count.
module stark_dsq_compact
    import stark_pkg::*;
(
    input  logic [DEC_WIDTH-1:0]      slot_v,
    output logic [DEC_WIDTH-1:0][1:0] wr_off,
    output logic [2:0]                enq_n
);

    // Each valid slot lands after all lower-numbered valid slots
    always_comb begin
        logic [2:0] acc;
        acc    = '0;
        wr_off = '0;
        for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
            wr_off[i] = acc[1:0];
            acc       = acc + {2'b00, slot_v[i]};
        end
        enq_n = acc;
    end

endmodule

// File: rtl/stark_decode_sched.sv
// Micro-op queue and 4-wide group scheduler in front of the Stark decoders.
module stark_decode_sched
    import stark_pkg::*;
#(
    parameter int unsigned QDEPTH = 16,
    // Must match the line field width of dsq_entry_t
    parameter int unsigned LTAG_W = stark_pkg::LTAG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_slot_v,
    input  micro_op_t [3:0]             in_uop,
    input  logic [3:0][3:0]             in_pos,
    input  logic [LTAG_W-1:0]           in_line,
    input  logic                        ck_valid,
    input  logic [LTAG_W-1:0]           ck_line,
    input  logic [15:0]                 ck_mask,
    input  logic                        out_ready,
    output logic [3:0]                  out_v,
    output logic [3:0]                  out_nop,
    output micro_op_t [3:0]             out_uop,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int unsigned IDX_W = $clog2(QDEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    dsq_entry_t              mem_q [QDEPTH];
    dsq_entry_t              mem_d [QDEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic [3:0]              out_v_q, out_v_d, out_nop_q, out_nop_d;
    micro_op_t [3:0]         out_uop_q, out_uop_d;

    logic [DEC_WIDTH-1:0][1:0] wr_off;
    logic [2:0]                cmp_n;
    logic                      fire, load;
    logic [2:0]                enq_n, avail_n, deq_n;

    stark_dsq_compact u_compact (
        .slot_v (in_slot_v),
        .wr_off (wr_off),
        .enq_n  (cmp_n)
    );

    function automatic logic ck_hit(input logic v, input logic [LTAG_W-1:0] cl,
                                    input logic [15:0] m, input logic [LTAG_W-1:0] l,
                                    input logic [3:0] p);
        return v && (l == cl) && m[p];
    endfunction

    // Next-state for queue storage, pointers, ready and the presented group
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        fire    = in_valid & in_ready_q;
        enq_n   = fire ? cmp_n : 3'd0;
        load    = out_ready | ~(|out_v_q);
        avail_n = (count_q >= PTR_W'(DEC_WIDTH)) ? 3'd4 : count_q[2:0];
        deq_n   = load ? avail_n : 3'd0;

        // Constant kill applies to every stored entry, including ones loading now
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (ck_hit(ck_valid, ck_line, ck_mask, mem_q[i].line, mem_q[i].pos))
                mem_d[i].kill = 1'b1;
        end

        if (fire) begin
            for (int unsigned s = 0; s < DEC_WIDTH; s++) begin
                if (in_slot_v[s]) begin
                    idx = tail_q[IDX_W-1:0] + IDX_W'(wr_off[s]);
                    mem_d[idx].uop  = in_uop[s];
                    mem_d[idx].pos  = in_pos[s];
                    mem_d[idx].line = in_line;
                    mem_d[idx].kill = ck_hit(ck_valid, ck_line, ck_mask, in_line, in_pos[s]);
                end
            end
        end

        out_v_d   = out_v_q;
        out_nop_d = out_nop_q;
        out_uop_d = out_uop_q;
        head_d    = head_q;
        if (load) begin
            for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
                idx = head_q[IDX_W-1:0] + IDX_W'(i);
                if (i < 32'(avail_n)) begin
                    out_v_d[i]   = 1'b1;
                    out_uop_d[i] = mem_q[idx].uop;
                    out_nop_d[i] = mem_q[idx].kill |
                                   ck_hit(ck_valid, ck_line, ck_mask, mem_q[idx].line, mem_q[idx].pos);
                end else begin
                    out_v_d[i]   = 1'b0;
                    out_uop_d[i] = '0;
                    out_nop_d[i] = 1'b0;
                end
            end
            head_d = head_q + PTR_W'(avail_n);
        end

        tail_d     = tail_q + PTR_W'(enq_n);
        count_d    = count_q + PTR_W'(enq_n) - PTR_W'(deq_n);
        in_ready_d = (PTR_W'(QDEPTH) - count_d) >= PTR_W'(DEC_WIDTH);

        // Flush wins over enqueue, kill and load in the same cycle
        if (flush) begin
            for (int unsigned i = 0; i < QDEPTH; i++) mem_d[i] = mem_q[i];
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            out_v_d    = '0;
            out_nop_d  = '0;
            out_uop_d  = '0;
            in_ready_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            out_v_q    <= '0;
            out_nop_q  <= '0;
            out_uop_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            out_v_q    <= out_v_d;
            out_nop_q  <= out_nop_d;
            out_uop_q  <= out_uop_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_v    = out_v_q;
    assign out_nop  = out_nop_q;
    assign out_uop  = out_uop_q;
    assign q_count  = count_q;

    // Upstream must never offer a group while the queue is not ready
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(in_valid && !in_ready_q && !flush));

endmodule
